// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller: state encoding,
// counter sizing helper and the fixed duty-cycle code.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_PS_APPLY  = 3'd4,
        ST_FAIL      = 3'd5
    } pll_state_e;

    localparam logic [3:0] DUTYDA_VAL = 4'b1000;

    // Width of the shared cycle counter: enough bits to hold the largest timing parameter.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(16, 50000, 1024, 64);

endpackage

// File: rtl/pll_lock_ctrl_sync2.sv
// Two-flop synchronizer bringing the raw PLL lock into the clkin domain.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset pulse, lock wait with retries, stability
// qualification, run mode with phase-shift updates, and a sticky fail state.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int LOCK_WAIT  = 50000,
    parameter int STABLE_CYC = 1024,
    parameter int MAX_RETRY  = 7,
    parameter int PS_SETTLE  = 64
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    input  logic       ps_req,
    input  logic [3:0] ps_val,
    output logic       ps_ack,
    output logic       locked,
    output logic       rst_out,
    output logic [2:0] retry_cnt,
    output logic       fail,
    output pll_state_e dbg_state_o
);

    localparam int CNT_W = cnt_width(RST_CYC, LOCK_WAIT, STABLE_CYC, PS_SETTLE);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);
    // The WAIT_LOCK cycle that first sees lock_s=1 is the first of the
    // STABLE_CYC qualifying cycles, so STABLE itself runs one cycle short.
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYC - 2);
    localparam logic [CNT_W-1:0] PS_LAST   = CNT_W'(PS_SETTLE - 1);
    localparam logic [CNT_W-1:0] PS_DONE   = CNT_W'(PS_SETTLE);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic [3:0]       psda_q, psda_d;
    logic             ack_q, ack_d;
    logic             lock_s;
    logic [2:0]       retry_inc;

    sync2 u_sync2 (
        .clk_i (clkin),
        .rst_i (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    assign retry_inc = retry_q + 3'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        psda_d  = psda_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == LOCK_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == 3'(MAX_RETRY)) ? ST_FAIL : ST_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 3'd0;
                end
            end
            ST_RUN: begin
                // Lock loss takes priority over a pending phase-shift request.
                if (!lock_s) begin
                    state_d = ST_RST;
                end else if (ps_req) begin
                    state_d = ST_PS_APPLY;
                    psda_d  = ps_val;
                end
            end
            ST_PS_APPLY: begin
                if (!lock_s) begin
                    state_d = ST_RST;
                end else begin
                    if (cnt_q == PS_LAST) ack_d = 1'b1;
                    if (cnt_q == PS_DONE) state_d = ST_RUN;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_RST;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            retry_q <= 3'd0;
            psda_q  <= 4'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            psda_q  <= psda_d;
            ack_q   <= ack_d;
        end
    end

    assign pll_reset   = (state_q == ST_RST) || (state_q == ST_FAIL);
    assign locked      = (state_q == ST_RUN) || (state_q == ST_PS_APPLY);
    assign rst_out     = ~locked;
    assign fail        = (state_q == ST_FAIL);
    assign retry_cnt   = retry_q;
    assign psda        = psda_q;
    assign ps_ack      = ack_q;
    assign dutyda      = DUTYDA_VAL;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with shortened timing parameters.
module tb_pll_lock_ctrl;
    import pll_ctrl_pkg::*;

    localparam int RST_CYC    = 4;
    localparam int LOCK_WAIT  = 20;
    localparam int STABLE_CYC = 8;
    localparam int MAX_RETRY  = 2;
    localparam int PS_SETTLE  = 3;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       ps_req;
    logic [3:0] ps_val;
    logic       ps_ack;
    logic       locked;
    logic       rst_out;
    logic [2:0] retry_cnt;
    logic       fail;
    pll_state_e dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int n;
    int acks;

    always #5 clkin = ~clkin;

    pll_lock_ctrl #(
        .RST_CYC    (RST_CYC),
        .LOCK_WAIT  (LOCK_WAIT),
        .STABLE_CYC (STABLE_CYC),
        .MAX_RETRY  (MAX_RETRY),
        .PS_SETTLE  (PS_SETTLE)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .psda        (psda),
        .dutyda      (dutyda),
        .ps_req      (ps_req),
        .ps_val      (ps_val),
        .ps_ack      (ps_ack),
        .locked      (locked),
        .rst_out     (rst_out),
        .retry_cnt   (retry_cnt),
        .fail        (fail),
        .dbg_state_o (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic wait_locked(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound && locked !== 1'b1) begin
            tick();
            cycles++;
        end
    endtask

    task automatic count_acks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (ps_ack === 1'b1) cnt++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        ps_req   = 1'b0;
        ps_val   = 4'h0;

        // Reset state and normal lock acquisition
        tick(2);
        check_eq("rst_pll_reset", pll_reset, 1);
        check_eq("rst_psda", psda, 0);
        check_eq("rst_dutyda", dutyda, 4'b1000);
        check_eq("rst_ps_ack", ps_ack, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_rst_out", rst_out, 1);
        check_eq("rst_retry", retry_cnt, 0);
        check_eq("rst_fail", fail, 0);
        reset = 1'b0;
        n = 1;
        while (n < 20) begin
            tick();
            if (pll_reset !== 1'b1) break;
            n++;
        end
        check_eq("pll_reset_len", n, 4);
        tick(6);
        pll_lock = 1'b1;
        wait_locked(40, n);
        check_eq("lock_latency", n, 10);
        check_eq("run_rst_out", rst_out, 0);
        check_eq("run_pll_reset", pll_reset, 0);
        check_eq("run_retry", retry_cnt, 0);

        // Phase-shift request in RUN
        ps_val = 4'h5;
        ps_req = 1'b1;
        tick();
        check_eq("ps_psda", psda, 5);
        check_eq("ps_ack_early", ps_ack, 0);
        check_eq("ps_locked", locked, 1);
        n = 1;
        while (n < 10 && ps_ack !== 1'b1) begin
            tick();
            n++;
        end
        check_eq("ps_ack_latency", n, 4);
        check_eq("ps_locked_at_ack", locked, 1);
        ps_req = 1'b0;
        tick();
        check_eq("ps_ack_pulse", ps_ack, 0);
        check_eq("ps_back_run", dbg_state, ST_RUN);
        count_acks(5, acks);
        check_eq("ps_no_extra_ack", acks, 0);
        check_eq("ps_locked_after", locked, 1);

        // Lock loss coinciding with ps_req at the synchronized lock
        pll_lock = 1'b0;
        tick();
        check_eq("drop_t1_rst_out", rst_out, 0);
        tick();
        check_eq("drop_t2_rst_out", rst_out, 0);
        ps_val = 4'hA;
        ps_req = 1'b1;
        tick();
        check_eq("drop_rst_out", rst_out, 1);
        check_eq("drop_pll_reset", pll_reset, 1);
        check_eq("drop_state", dbg_state, ST_RST);
        check_eq("drop_psda_kept", psda, 5);
        count_acks(10, acks);
        check_eq("drop_no_ack", acks, 0);
        check_eq("drop_psda_final", psda, 5);
        ps_req = 1'b0;

        // Reset asserted while in PS_APPLY
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pll_lock = 1'b1;
        wait_locked(60, n);
        check_eq("relock_latency", n, 12);
        ps_val = 4'h9;
        ps_req = 1'b1;
        tick();
        check_eq("mid_psda", psda, 9);
        check_eq("mid_state", dbg_state, ST_PS_APPLY);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_psda", psda, 0);
        check_eq("mid_rst_pll_reset", pll_reset, 1);
        check_eq("mid_rst_locked", locked, 0);
        check_eq("mid_rst_ack", ps_ack, 0);
        check_eq("mid_rst_state", dbg_state, ST_RST);
        reset  = 1'b0;
        ps_req = 1'b0;

        // Two-cycle lock glitch during STABLE
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(6);
        pll_lock = 1'b1;
        tick(4);
        pll_lock = 1'b0;
        tick(2);
        check_eq("glitch_in_stable", dbg_state, ST_STABLE);
        pll_lock = 1'b1;
        tick();
        check_eq("glitch_state", dbg_state, ST_WAIT_LOCK);
        check_eq("glitch_retry", retry_cnt, 0);
        check_eq("glitch_locked", locked, 0);
        wait_locked(40, n);
        check_eq("glitch_relock", n, 9);
        check_eq("glitch_retry_run", retry_cnt, 0);

        // Lock never arrives: two attempts then FAIL
        pll_lock = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(23);
        check_eq("att1_retry", retry_cnt, 0);
        check_eq("att1_pll_reset", pll_reset, 0);
        tick();
        check_eq("att1_end_retry", retry_cnt, 1);
        check_eq("att1_end_pll_reset", pll_reset, 1);
        check_eq("att1_end_fail", fail, 0);
        tick(23);
        check_eq("att2_retry", retry_cnt, 1);
        check_eq("att2_pll_reset", pll_reset, 0);
        check_eq("att2_fail", fail, 0);
        tick();
        check_eq("fail_flag", fail, 1);
        check_eq("fail_pll_reset", pll_reset, 1);
        check_eq("fail_rst_out", rst_out, 1);
        check_eq("fail_retry", retry_cnt, 2);
        check_eq("fail_state", dbg_state, ST_FAIL);
        ps_val = 4'h3;
        ps_req = 1'b1;
        pll_lock = 1'b1;
        count_acks(10, acks);
        check_eq("fail_no_ack", acks, 0);
        check_eq("fail_sticky", fail, 1);
        check_eq("fail_hold_pll_reset", pll_reset, 1);
        check_eq("fail_psda", psda, 0);
        check_eq("fail_locked", locked, 0);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ps_req = 1'b0;
        check_eq("clr_fail", fail, 0);
        check_eq("clr_retry", retry_cnt, 0);
        check_eq("clr_pll_reset", pll_reset, 1);
        check_eq("clr_rst_out", rst_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYC, default 16: cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_WAIT, default 50000: cycles allowed for lock per attempt (1 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_CYC, default 1024: cycles lock must stay continuously high before release.
REQ-004 SHALL have parameter MAX_RETRY, default 7: failed attempts before entering FAIL.
REQ-005 SHALL have parameter PS_SETTLE, default 64: settle cycles after a phase-shift update.
REQ-006 SHALL have port clkin, input, 1 bit: single clock (free-running 50 MHz reference), all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port pll_lock, input, 1 bit: raw PLL lock, asynchronous to clkin.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives PLL RESET.
REQ-010 SHALL have port psda, output, 4 bits: drives PLL PSDA (phase step).
REQ-011 SHALL have port dutyda, output, 4 bits: drives PLL DUTYDA; constant 4'b1000.
REQ-012 SHALL have port ps_req, input, 1 bit: phase-shift request, level.
REQ-013 SHALL have port ps_val, input, 4 bits: requested phase step.
REQ-014 SHALL have port ps_ack, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port locked, output, 1 bit: high only in RUN and PS_APPLY.
REQ-016 SHALL have port rst_out, output, 1 bit: downstream active-high reset, equal to NOT locked.
REQ-017 SHALL have port retry_cnt, output, 3 bits: failed attempts since last RUN.
REQ-018 SHALL have port fail, output, 1 bit: sticky failure flag.

Function
REQ-019 SHALL synchronize pll_lock through two flops into lock_s; all decisions use lock_s (2-cycle latency).
REQ-020 SHALL implement states RST, WAIT_LOCK, STABLE, RUN, PS_APPLY and FAIL with one shared cycle counter, cleared on every state entry.
REQ-021 In RST, SHALL hold pll_reset=1 for exactly RST_CYC cycles, then go to WAIT_LOCK with pll_reset=0.
REQ-022 In WAIT_LOCK, lock_s=1 SHALL move to STABLE; counter reaching LOCK_WAIT-1 with lock_s=0 SHALL increment retry_cnt and go to RST, or to FAIL if the incremented value equals MAX_RETRY.
REQ-023 In STABLE, lock_s=0 SHALL return to WAIT_LOCK without incrementing retry_cnt; STABLE_CYC consecutive cycles of lock_s=1 SHALL move to RUN and clear retry_cnt.
REQ-024 In RUN, locked=1 and rst_out=0 from the first RUN cycle; lock_s=0 SHALL move to RST, with rst_out=1 and pll_reset=1 on the next cycle.
REQ-025 In RUN, ps_req=1 SHALL move to PS_APPLY and load psda<=ps_val on the transition; ps_req asserted in any other state stays pending until RUN.
REQ-026 In PS_APPLY, SHALL wait PS_SETTLE cycles, pulse ps_ack for 1 cycle, return to RUN; lock_s=0 during settle SHALL go to RST with no ack and psda retained.
REQ-027 Requester SHALL hold ps_req and ps_val stable until ps_ack; ps_req must drop the cycle after ps_ack, else a second shift starts.
REQ-028 In FAIL, SHALL hold pll_reset=1, fail=1, rst_out=1 and ignore ps_req; only reset exits FAIL.
REQ-029 Lock loss and ps_req in the same RUN cycle SHALL resolve to RST (lock loss wins).

Reset
REQ-030 On reset=1, SHALL enter RST with counter=0, pll_reset=1, psda=0, dutyda=4'b1000, ps_ack=0, locked=0, rst_out=1, retry_cnt=0, fail=0 and sync flops=0.
REQ-031 Reset asserted mid-operation, including in FAIL or PS_APPLY, SHALL restart the sequence from RST on the next cycle.

Structure
REQ-032 Package pll_ctrl_pkg SHALL hold the state enum, the counter width (clog2 of the max parameter) and the DUTYDA constant.
REQ-033 Sub-module sync2 SHALL implement the 2-flop synchronizer; everything else stays in pll_lock_ctrl.

Verification (RST_CYC=4, LOCK_WAIT=20, STABLE_CYC=8, MAX_RETRY=2, PS_SETTLE=3)
REQ-034 Lock high 10 cycles after reset release -> pll_reset high 4 cycles, locked=1 and rst_out=0 after lock + 2 sync + 8 stable cycles.
REQ-035 Lock never asserts -> two 4+20 attempts, retry_cnt 1 then 2, fail=1 with pll_reset=1 persisting; reset clears.
REQ-036 Lock glitch low 2 cycles during STABLE -> back to WAIT_LOCK, retry_cnt stays 0, full 8-cycle stable window restarts.
REQ-037 In RUN, ps_req with ps_val=4'h5 -> psda=5 next cycle, ps_ack single pulse after 3 settle cycles, locked stays 1.
REQ-038 Lock drops in RUN in the same cycle as ps_req -> RST taken, no ps_ack, rst_out=1 within 3 cycles of the pll_lock fall.
